// File: rtl/axis_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_result_packer
// Purpose  : Packs a multi-word two's-complement result packet into one signed
//            OUT_WIDTH word, sign-extending narrow results, saturating wide ones.
// Revision : 1.0
// ============================================================================
module axis_result_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  // Index at which every further word lands entirely above OUT_WIDTH.
  localparam int c_MAX_IDX = (OUT_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int c_IDX_W   = $clog2(c_MAX_IDX + 1);
  localparam int c_EXT_W   = (c_MAX_IDX + 1) * IN_WIDTH;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_IDX_W-1:0]     r_word_idx;
  logic [OUT_WIDTH-1:0]   r_acc;
  logic                   r_upper_zero;
  logic                   r_upper_one;
  logic [OUT_WIDTH-1:0]   r_tdata;
  logic                   r_tuser;

  int                     w_ofs;
  logic [c_EXT_W-1:0]     w_shift;
  logic [c_EXT_W-1:0]     w_mask;
  logic [c_EXT_W-1:0]     w_ext;
  logic [OUT_WIDTH-1:0]   w_acc_nxt;
  logic                   w_uz_nxt;
  logic                   w_uo_nxt;
  logic                   w_sign;
  logic                   w_wide;
  logic                   w_fits;
  logic [OUT_WIDTH-1:0]   w_pack;
  logic                   w_sat;
  logic                   w_s_hs;
  logic                   w_m_hs;

  // Place the incoming word at its bit offset in a window wide enough to hold
  // the part that spills past OUT_WIDTH.
  always_comb begin
    w_ofs     = int'(r_word_idx) * IN_WIDTH;
    w_shift   = {{(c_EXT_W-IN_WIDTH){1'b0}}, s_axis_tdata} << w_ofs;
    w_mask    = {{(c_EXT_W-IN_WIDTH){1'b0}}, {IN_WIDTH{1'b1}}} << w_ofs;
    w_ext     = {c_EXT_W{1'b1}} << (w_ofs + IN_WIDTH);
    w_acc_nxt = r_acc | w_shift[OUT_WIDTH-1:0];
    w_uz_nxt  = r_upper_zero & (w_shift[c_EXT_W-1:OUT_WIDTH] == '0);
    w_uo_nxt  = r_upper_one &
                ((w_shift[c_EXT_W-1:OUT_WIDTH] | ~w_mask[c_EXT_W-1:OUT_WIDTH]) == '1);
    w_sign    = s_axis_tdata[IN_WIDTH-1];
    w_wide    = (w_ofs + IN_WIDTH) > OUT_WIDTH;
    w_fits    = (w_acc_nxt[OUT_WIDTH-1] == w_sign) && (w_sign ? w_uo_nxt : w_uz_nxt);
    w_pack    = w_acc_nxt;
    w_sat     = 1'b0;
    if (!w_wide) begin
      w_pack = w_acc_nxt | (w_sign ? w_ext[OUT_WIDTH-1:0] : '0);
    end else if (!w_fits) begin
      w_pack = w_sign ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      w_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (r_state)
      S_COLLECT: begin
        s_axis_tready = !reset;
        if (s_axis_tvalid && s_axis_tlast) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  assign w_s_hs       = s_axis_tvalid && s_axis_tready;
  assign w_m_hs       = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata = r_tdata;
  assign m_axis_tuser = r_tuser;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_idx   <= '0;
      r_acc        <= '0;
      r_upper_zero <= 1'b1;
      r_upper_one  <= 1'b1;
      r_tdata      <= '0;
      r_tuser      <= 1'b0;
    end else if (w_s_hs) begin
      r_acc        <= w_acc_nxt;
      r_upper_zero <= w_uz_nxt;
      r_upper_one  <= w_uo_nxt;
      if (r_word_idx != c_IDX_W'(c_MAX_IDX)) r_word_idx <= r_word_idx + 1'b1;
      if (s_axis_tlast) begin
        r_tdata <= w_pack;
        r_tuser <= w_sat;
      end
    end else if (w_m_hs) begin
      r_word_idx   <= '0;
      r_acc        <= '0;
      r_upper_zero <= 1'b1;
      r_upper_one  <= 1'b1;
    end
  end

endmodule
`default_nettype wire
